// File: rtl/slot_sensor_conditioner_pkg.sv
// Shared parking-bay types and constants.
// The display stage uses the same slot vector typedef.
package parking_pkg;

    localparam int NUM_SLOTS = 5;
    localparam int COUNT_W   = 3;

    typedef logic [NUM_SLOTS-1:0] slot_vec_t;
    typedef logic [COUNT_W-1:0]   slot_count_t;

    // Number of occupied bays in a slot vector.
    function automatic slot_count_t popcount(input slot_vec_t v);
        slot_count_t n;
        n = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            n = n + COUNT_W'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/slot_sensor_conditioner_if.sv
// Sensor/occupancy bundle between the raw bay sensors and the display stage.
// The conditioner uses the slave modport; the sensor side uses master.
interface slot_sensor_if;
    import parking_pkg::*;

    slot_vec_t   sensor_raw;
    slot_vec_t   parking_slots;
    slot_count_t occupied_count;
    logic        lot_full;
    slot_vec_t   arrive_pulse;
    slot_vec_t   depart_pulse;

    modport master (
        output sensor_raw,
        input  parking_slots,
        input  occupied_count,
        input  lot_full,
        input  arrive_pulse,
        input  depart_pulse
    );

    modport slave (
        input  sensor_raw,
        output parking_slots,
        output occupied_count,
        output lot_full,
        output arrive_pulse,
        output depart_pulse
    );

endinterface

// File: rtl/slot_sensor_conditioner_cell.sv
// One bay: two-flop synchroniser, tick-driven agreement counter, stable bit
// and single-cycle rise/fall pulses aligned with the stable bit change.
module slot_debounce_cell #(
    parameter int DEBOUNCE_TICKS = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    input  logic sample_tick,
    output logic stable,
    output logic stable_next,
    output logic rise,
    output logic fall
);

    localparam int CNT_W = $clog2(DEBOUNCE_TICKS + 1);

    logic             sync1_reg;
    logic             sync2_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic             stable_reg;
    logic             rise_reg;
    logic             rise_next;
    logic             fall_reg;
    logic             fall_next;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_reg  <= 1'b0;
            sync2_reg  <= 1'b0;
            cnt_reg    <= '0;
            stable_reg <= 1'b0;
            rise_reg   <= 1'b0;
            fall_reg   <= 1'b0;
        end else begin
            sync1_reg  <= raw;
            sync2_reg  <= sync1_reg;
            cnt_reg    <= cnt_next;
            stable_reg <= stable_next;
            rise_reg   <= rise_next;
            fall_reg   <= fall_next;
        end
    end

    // Any agreeing sample restarts the count, so only an unbroken run of
    // disagreeing ticks flips the stable level.
    always_comb begin
        cnt_next    = cnt_reg;
        stable_next = stable_reg;
        rise_next   = 1'b0;
        fall_next   = 1'b0;
        if (sample_tick) begin
            if (sync2_reg == stable_reg) begin
                cnt_next = '0;
            end else if (int'(cnt_reg) + 1 >= DEBOUNCE_TICKS) begin
                stable_next = ~stable_reg;
                cnt_next    = '0;
                rise_next   = ~stable_reg;
                fall_next   = stable_reg;
            end else begin
                cnt_next = cnt_reg + CNT_W'(1);
            end
        end
    end

    assign stable = stable_reg;
    assign rise   = rise_reg;
    assign fall   = fall_reg;

endmodule

// File: rtl/slot_sensor_conditioner.sv
// Conditions the raw bay sensors into a debounced occupancy vector with a
// registered occupied count, full flag and per-bay arrive/depart pulses.
module slot_sensor_conditioner
    import parking_pkg::*;
#(
    parameter int SAMPLE_DIV     = 500000,
    parameter int DEBOUNCE_TICKS = 4
) (
    input logic          clock,
    input logic          reset,
    slot_sensor_if.slave bus
);

    localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

    logic [DIV_W-1:0] presc_reg;
    logic [DIV_W-1:0] presc_next;
    logic             sample_tick;

    slot_vec_t   stable_vec;
    slot_vec_t   stable_next_vec;
    slot_vec_t   rise_vec;
    slot_vec_t   fall_vec;
    slot_count_t count_reg;
    slot_count_t count_next;
    logic        full_reg;
    logic        full_next;

    assign sample_tick = (presc_reg == DIV_W'(SAMPLE_DIV - 1));

    always_comb begin
        presc_next = presc_reg + DIV_W'(1);
        if (sample_tick) begin
            presc_next = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            presc_reg <= '0;
        end else begin
            presc_reg <= presc_next;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_bay
            slot_debounce_cell #(
                .DEBOUNCE_TICKS (DEBOUNCE_TICKS)
            ) u_cell (
                .clock       (clock),
                .reset       (reset),
                .raw         (bus.sensor_raw[gi]),
                .sample_tick (sample_tick),
                .stable      (stable_vec[gi]),
                .stable_next (stable_next_vec[gi]),
                .rise        (rise_vec[gi]),
                .fall        (fall_vec[gi])
            );
        end
    endgenerate

    // Counting the next-state vector keeps count and flag on the same edge
    // as the occupancy change, netting simultaneous arrivals and departures.
    always_comb begin
        count_next = popcount(stable_next_vec);
        full_next  = (count_next == COUNT_W'(NUM_SLOTS));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
            full_reg  <= 1'b0;
        end else begin
            count_reg <= count_next;
            full_reg  <= full_next;
        end
    end

    assign bus.parking_slots  = stable_vec;
    assign bus.occupied_count = count_reg;
    assign bus.lot_full       = full_reg;
    assign bus.arrive_pulse   = rise_vec;
    assign bus.depart_pulse   = fall_vec;

endmodule
